// File: rtl/axi_stream_strip_header.sv
// Removes a strip_len-byte header from the front of an AXI-Stream packet.
// The header goes out on its own channel and the payload is re-packed MSB-aligned.
module axi_stream_strip_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int LEN_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic [LEN_WD-1:0]       strip_len,
  output logic                    valid_hdr,
  output logic [DATA_WD-1:0]      hdr_out,
  output logic [DATA_BYTE_WD-1:0] keep_hdr,
  input  logic                    ready_hdr,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);

  typedef enum logic [1:0] {FIRST, BODY, FLUSH} state_t;

  localparam logic [LEN_WD-1:0] BYTES = LEN_WD'(DATA_BYTE_WD);

  function automatic logic [DATA_BYTE_WD-1:0] msb_ones(input logic [LEN_WD-1:0] n);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      if (i < int'(n)) m[DATA_BYTE_WD-1-i] = 1'b1;
    return m;
  endfunction

  function automatic logic [LEN_WD-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [LEN_WD-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + LEN_WD'(k[i]);
    return c;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_t                  state_q, state_d;
  logic [LEN_WD-1:0]       len_q, len_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [LEN_WD-1:0]       res_cnt_q, res_cnt_d;
  logic                    valid_out_q, valid_out_d;
  logic [DATA_WD-1:0]      data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
  logic                    last_out_q, last_out_d;
  logic                    valid_hdr_q, valid_hdr_d;
  logic [DATA_WD-1:0]      hdr_q, hdr_d;
  logic [DATA_BYTE_WD-1:0] keep_hdr_q, keep_hdr_d;

  logic                    pay_free, hdr_free, accept;
  logic [DATA_WD-1:0]      din_m;
  logic [LEN_WD-1:0]       k_in, l_in, rem_len, body_keep_n;

  // Bytes beyond keep_in are zeroed up front so every shift below zero-fills naturally.
  assign din_m       = data_in & byte_mask(keep_in);
  assign k_in        = popcnt(keep_in);
  assign l_in        = (strip_len > BYTES) ? BYTES : strip_len;
  assign rem_len     = BYTES - len_q;
  assign body_keep_n = rem_len + k_in;

  assign pay_free = !valid_out_q || ready_out;
  assign hdr_free = !valid_hdr_q || ready_hdr;
  assign ready_in = rst_n && (state_q != FLUSH) && pay_free && ((state_q != FIRST) || hdr_free);
  assign accept   = valid_in && ready_in;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    res_d       = res_q;
    res_cnt_d   = res_cnt_q;
    valid_out_d = valid_out_q && !ready_out;
    data_out_d  = data_out_q;
    keep_out_d  = keep_out_q;
    last_out_d  = last_out_q;
    valid_hdr_d = valid_hdr_q && !ready_hdr;
    hdr_d       = hdr_q;
    keep_hdr_d  = keep_hdr_q;
    case (state_q)
      FIRST: if (accept) begin
        len_d = l_in;
        if (l_in == '0) begin
          valid_out_d = 1'b1;
          data_out_d  = din_m;
          keep_out_d  = keep_in;
          last_out_d  = last_in;
          state_d     = last_in ? FIRST : BODY;
        end else begin
          valid_hdr_d = 1'b1;
          hdr_d       = din_m & byte_mask(msb_ones(l_in));
          keep_hdr_d  = keep_in & msb_ones(l_in);
          res_d       = din_m << {l_in, 3'b000};
          res_cnt_d   = (k_in > l_in) ? k_in - l_in : '0;
          if (!last_in)         state_d = BODY;
          else if (k_in > l_in) state_d = FLUSH;
          else                  state_d = FIRST;
        end
      end
      BODY: if (accept) begin
        valid_out_d = 1'b1;
        if (len_q == '0) begin
          data_out_d = din_m;
          keep_out_d = keep_in;
          last_out_d = last_in;
          state_d    = last_in ? FIRST : BODY;
        end else begin
          // Residue is held MSB-aligned, so its W-L bytes sit directly above the new L bytes.
          data_out_d = res_q | (din_m >> {rem_len, 3'b000});
          res_d      = din_m << {len_q, 3'b000};
          keep_out_d = '1;
          last_out_d = 1'b0;
          if (last_in) begin
            if (k_in <= len_q) begin
              keep_out_d = msb_ones(body_keep_n);
              last_out_d = 1'b1;
              state_d    = FIRST;
            end else begin
              res_cnt_d = k_in - len_q;
              state_d   = FLUSH;
            end
          end
        end
      end
      FLUSH: if (pay_free) begin
        valid_out_d = 1'b1;
        data_out_d  = res_q;
        keep_out_d  = msb_ones(res_cnt_q);
        last_out_d  = 1'b1;
        state_d     = FIRST;
      end
      default: state_d = FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FIRST;
      len_q       <= '0;
      res_q       <= '0;
      res_cnt_q   <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      keep_out_q  <= '0;
      last_out_q  <= 1'b0;
      valid_hdr_q <= 1'b0;
      hdr_q       <= '0;
      keep_hdr_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      res_q       <= res_d;
      res_cnt_q   <= res_cnt_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      keep_out_q  <= keep_out_d;
      last_out_q  <= last_out_d;
      valid_hdr_q <= valid_hdr_d;
      hdr_q       <= hdr_d;
      keep_hdr_q  <= keep_hdr_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign keep_out  = keep_out_q;
  assign last_out  = last_out_q;
  assign valid_hdr = valid_hdr_q;
  assign hdr_out   = hdr_q;
  assign keep_hdr  = keep_hdr_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: a byte-queue model predicts
// header and payload beats, which are compared as the DUT hands them off.
module tb_axi_stream_strip_header;
  localparam int DATA_WD = 32;
  localparam int W       = DATA_WD / 8;
  localparam int LEN_WD  = $clog2(W + 1);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               valid_in = 1'b0;
  logic [DATA_WD-1:0] data_in = '0;
  logic [W-1:0]       keep_in = '0;
  logic               last_in = 1'b0;
  logic               ready_in;
  logic [LEN_WD-1:0]  strip_len = '0;
  logic               valid_hdr;
  logic [DATA_WD-1:0] hdr_out;
  logic [W-1:0]       keep_hdr;
  logic               ready_hdr = 1'b1;
  logic               valid_out;
  logic [DATA_WD-1:0] data_out;
  logic [W-1:0]       keep_out;
  logic               last_out;
  logic               ready_out = 1'b1;

  axi_stream_strip_header #(.DATA_WD(DATA_WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in), .strip_len(strip_len),
    .valid_hdr(valid_hdr), .hdr_out(hdr_out), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_WD-1:0] d;
    logic [W-1:0]       k;
    logic               l;
  } beat_t;

  beat_t      exp_pay[$];
  beat_t      exp_hdr[$];
  logic [7:0] pkt[$];
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  bit         rnd_rdy = 1'b0;
  bit         gap_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Header = first min(L, first-beat bytes) bytes; payload = everything after, repacked.
  task automatic push_model(input int sl);
    int    L, k0, h, n;
    beat_t x;
    L  = (sl > W) ? W : sl;
    k0 = (pkt.size() < W) ? pkt.size() : W;
    h  = (L < k0) ? L : k0;
    if (L > 0) begin
      x = '0;
      for (int i = 0; i < h; i++) begin
        x.d[DATA_WD-1-8*i -: 8] = pkt[i];
        x.k[W-1-i] = 1'b1;
      end
      exp_hdr.push_back(x);
    end
    for (int off = h; off < pkt.size(); off += W) begin
      x = '0;
      n = pkt.size() - off;
      if (n > W) n = W;
      for (int i = 0; i < n; i++) begin
        x.d[DATA_WD-1-8*i -: 8] = pkt[off+i];
        x.k[W-1-i] = 1'b1;
      end
      x.l = (off + W >= pkt.size());
      exp_pay.push_back(x);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
  task automatic drive_beat(input logic [DATA_WD-1:0] d, input logic [W-1:0] k,
                            input logic l, input logic [LEN_WD-1:0] sl);
    int t;
    t = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l; strip_len = sl;
    while (1) begin
      @(negedge clk);
      if (ready_in) break;
      t++;
      if (t > 300) begin
        chk("ready_in_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    data_in  = $urandom;
  endtask

  task automatic send_pkt(input int sl, input bit lat);
    logic [DATA_WD-1:0] d;
    logic [W-1:0]       k;
    int                 n;
    push_model(sl);
    for (int off = 0; off < pkt.size(); off += W) begin
      if (gap_en && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      n = pkt.size() - off;
      if (n > W) n = W;
      d = $urandom;
      k = '0;
      for (int i = 0; i < n; i++) begin
        d[DATA_WD-1-8*i -: 8] = pkt[off+i];
        k[W-1-i] = 1'b1;
      end
      drive_beat(d, k, (off + W >= pkt.size()), LEN_WD'(sl));
      if (lat && off == 0) begin
        chk("lat_hdr", valid_hdr, (sl > 0));
        if (sl == 0) chk("lat_pay", valid_out, 1);
      end
    end
  endtask

  task automatic load_pkt(input logic [DATA_WD-1:0] w0, input logic [DATA_WD-1:0] w1, input int n);
    logic [2*DATA_WD-1:0] all;
    all = {w0, w1};
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(all[2*DATA_WD-1-8*i -: 8]);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk(tag, exp_pay.size() + exp_hdr.size(), 0);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_vout"}, valid_out, 0);
    chk({tag, "_dout"}, data_out, 0);
    chk({tag, "_kout"}, keep_out, 0);
    chk({tag, "_lout"}, last_out, 0);
    chk({tag, "_vhdr"}, valid_hdr, 0);
    chk({tag, "_hdr"}, hdr_out, 0);
    chk({tag, "_khdr"}, keep_hdr, 0);
    chk({tag, "_rdy"}, ready_in, 0);
  endtask

  // Stall generator: readies change just after each posedge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      ready_out = ($urandom_range(0, 3) != 0);
      ready_hdr = ($urandom_range(0, 2) != 0);
    end
  end

  beat_t      pe, he;
  bit         p_hold = 1'b0, h_hold = 1'b0;
  logic [DATA_WD+W:0] p_snap, h_snap;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      p_hold = 1'b0;
      h_hold = 1'b0;
    end else begin
      if (valid_out && !ready_out) chk("ready_in_stall", ready_in, 0);
      if (p_hold) begin
        chk("pay_hold_valid", valid_out, 1);
        chk("pay_hold_data", {data_out, keep_out, last_out}, p_snap);
      end
      if (h_hold) begin
        chk("hdr_hold_valid", valid_hdr, 1);
        chk("hdr_hold_data", {hdr_out, keep_hdr, 1'b0}, h_snap);
      end
      p_hold = valid_out && !ready_out;
      p_snap = {data_out, keep_out, last_out};
      h_hold = valid_hdr && !ready_hdr;
      h_snap = {hdr_out, keep_hdr, 1'b0};
      if (valid_out && ready_out) begin
        if (exp_pay.size() == 0) chk("pay_unexpected", 1, 0);
        else begin
          pe = exp_pay.pop_front();
          chk("pay_data", data_out, pe.d);
          chk("pay_keep", keep_out, pe.k);
          chk("pay_last", last_out, pe.l);
        end
      end
      if (valid_hdr && ready_hdr) begin
        if (exp_hdr.size() == 0) chk("hdr_unexpected", 1, 0);
        else begin
          he = exp_hdr.pop_front();
          chk("hdr_data", hdr_out, he.d);
          chk("hdr_keep", keep_hdr, he.k);
        end
      end
    end
  end

  initial begin
    #1;
    outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    load_pkt(32'hAABBCCDD, 32'h11223344, 8);  send_pkt(1, 0);
    load_pkt(32'hAABBCCDD, 32'h11220000, 6);  send_pkt(2, 0);
    drain("drain_l1_l2");
    load_pkt(32'hDEADBEEF, 32'h01020304, 8);  send_pkt(4, 1);
    load_pkt(32'hCAFEF00D, 32'h55667788, 8);  send_pkt(0, 1);
    load_pkt(32'hAABBCCDD, 32'h0, 4);         send_pkt(3, 0);
    load_pkt(32'hAABB0000, 32'h0, 2);         send_pkt(3, 0);
    load_pkt(32'h12345678, 32'h9ABC0000, 6);  send_pkt(7, 0);
    drain("drain_directed");

    // Reset in the middle of a BODY beat: packet is discarded.
    mon_en = 1'b0;
    drive_beat(32'hAABBCCDD, 4'hF, 1'b0, LEN_WD'(1));
    drive_beat(32'h11223344, 4'hF, 1'b0, LEN_WD'(1));
    chk("pre_rst_vout", valid_out, 1);
    #2 rst_n = 1'b0;
    #1;
    outputs_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    load_pkt(32'hAABBCCDD, 32'h11223344, 8);  send_pkt(1, 0);
    drain("drain_after_rst");

    rnd_rdy = 1'b1;
    gap_en  = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int n;
      n = $urandom_range(1, 13);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      send_pkt($urandom_range(0, 7), 0);
    end
    rnd_rdy = 1'b0;
    #1;
    ready_out = 1'b1;
    ready_hdr = 1'b1;
    drain("drain_random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
